// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw pins in, debounced level and change strobes out.
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic             any_change;
  logic [WIDTH-1:0] settling;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_changed,
    input  sw_rise,
    input  any_change,
    input  settling
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_changed,
    output sw_rise,
    output any_change,
    output settling
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit 2-FF synchroniser followed by a stable-level debounce filter with
// registered change/rise strobes for edge or IRQ logic.
module switch_debouncer #(
  parameter int unsigned     WIDTH           = 8,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input logic                 clk,
  input logic                 reset_n,
  switch_debouncer_if.slave   sw_if
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StStable, StCounting} state_e;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_changed;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_settling;
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_settle_nxt;

  assign w_mismatch = r_s2 ^ r_clean;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_acc;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc       = 1'b0;
      unique case (r_state)
        StStable: begin
          w_cnt_nxt = '0;
          if (w_mismatch[g]) begin
            w_state_nxt = StCounting;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        StCounting: begin
          // A bounce back to the accepted level discards the whole run.
          if (!w_mismatch[g]) begin
            w_state_nxt = StStable;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CntMax) begin
            w_acc       = 1'b1;
            w_state_nxt = StStable;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = StStable;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= StStable;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign w_accept[g]     = w_acc;
    assign w_settle_nxt[g] = (w_state_nxt == StCounting);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= RESET_VALUE;
      r_s2       <= RESET_VALUE;
      r_clean    <= RESET_VALUE;
      r_changed  <= '0;
      r_rise     <= '0;
      r_settling <= '0;
    end else begin
      r_s1       <= sw_if.sw_raw;
      r_s2       <= r_s1;
      r_clean    <= (r_clean & ~w_accept) | (r_s2 & w_accept);
      r_changed  <= w_accept;
      r_rise     <= w_accept & r_s2;
      r_settling <= w_settle_nxt;
    end
  end

  assign sw_if.sw_clean   = r_clean;
  assign sw_if.sw_changed = r_changed;
  assign sw_if.sw_rise    = r_rise;
  assign sw_if.settling   = r_settling;
  assign sw_if.any_change = |r_changed;

endmodule
